fuzzy_defuzzifier: RTL
======================

Name: fuzzy_defuzzifier

Overview:
- Consumes the stream of output fuzzy set ids (1..11) from the rule stage, each paired with a firing strength (membership degree).
- Computes the crisp control action as a centre-of-gravity weighted average: sum(mu*centre)/sum(mu).
- Sits between the rule base and the governor/actuator command register of the frequency-regulation controller.
- Division is sequential, restoring, one quotient bit per clock.

Parameters:
- CENTER_STEP, 256: spacing between adjacent output-set centres. Centre(k) = (k-6)*CENTER_STEP for k = 1..11, signed.
- ACC_W, 24: signed numerator accumulator width. Denominator width is 16.
- OUT_W, 16: signed crisp output width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  term present on in_set_id/in_mu.
- in_ready  out  1  block can accept a term.
- in_set_id  in  8  output fuzzy set id, same encoding as the rule stage output (0 = none, 1..11 valid).
- in_mu  in  8  firing strength, unsigned, 0..255.
- in_last  in  1  marks the final term of a frame.
- out_valid  out  1  crisp result available.
- out_ready  in  1  downstream accepts result.
- out_crisp  out  OUT_W  signed crisp value.
- out_bad_id  out  1  frame contained an id of 0 or >11.
- out_zero_w  out  1  frame total weight was 0.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low.
- Reset values: state ACC, in_ready=1, out_valid=0, out_crisp=0, out_bad_id=0, out_zero_w=0. Accumulators, counters and sticky flags are cleared.
- State ACC:
  - in_ready=1.
  - On in_valid&&in_ready with id in 1..11: num += in_mu*centre(id) (signed) and den += in_mu.
  - Id 0 or >11: term contributes nothing and sets sticky bad_id.
  - in_mu=0 is legal and contributes nothing.
  - Accepting a term with in_last=1 (that term is included) moves to DIV on the same edge.
- State DIV:
  - in_ready=0.
  - Restoring division of |num| by den, ACC_W iterations (24 clocks), one quotient bit per clock.
  - Followed by one FIX clock that applies the sign of num and truncates toward zero.
  - Quotient range is bounded by ±5*CENTER_STEP, so it fits OUT_W with no saturation at defaults.
- Zero weight: if den==0, the quotient is forced to 0 and zero_w is set. Latency is unchanged (fixed-latency rule).
- Latency: out_valid rises on the 26th rising clk edge after the edge that accepted the in_last term.
- State OUT:
  - out_valid=1. out_crisp, out_bad_id and out_zero_w are held stable until out_valid&&out_ready.
  - in_ready=0 in this state.
  - On the handshake edge: return to ACC, clear num, den and the sticky flags, deassert out_valid. in_ready=1 from the next cycle.
  - out_ready=1 already asserted when out_valid rises gives a one-cycle out_valid pulse.
- Backpressure: in_valid while in_ready=0 is ignored. The upstream holds the term; no term is lost or double-counted.
- Single-term frame (first term has in_last=1): legal. Result equals centre(id), or 0 if mu=0.
- Accumulator sizing: ACC_W=24 covers at least 16 terms at mu=255, |centre|=1280. Frames longer than 16 terms are out of contract; wrap-around is permitted and unchecked.
- Reset mid-frame or mid-division: asynchronous return to reset values. A partial frame is discarded and no out_valid is produced for it.
- out_crisp keeps its last delivered value in ACC/DIV; it is 0 after reset.

Test Plan:
- Reset, then frame {id11 mu255, last} -> 26 clocks after accept, out_valid=1, out_crisp=+1280, flags 0.
- Frame {id1 mu100},{id11 mu100,last} -> out_crisp=0. Frame {id4 mu200},{id6 mu56,last} -> out_crisp=-400.
- Truncation: {id7 mu1},{id6 mu2,last} -> +85. {id5 mu1},{id6 mu2,last} -> -85.
- Flags:
  - {id0 mu50},{id13 mu10},{id8 mu40,last} -> out_crisp=+512, out_bad_id=1.
  - {id3 mu0,last} -> out_crisp=0, out_zero_w=1, latency still 26.
- Handshakes:
  - Hold out_ready=0 for 10 clocks -> out_* stable, in_ready=0, in_valid terms ignored.
  - Release out_ready -> next frame accepted and the accumulator starts from 0.
- Assert rst_n=0 for 1 cycle during DIV of frame {id11 mu255,last} -> no out_valid. Next frame {id9 mu10,last} -> +768.

Source files
------------

// File: rtl/fuzzy_defuzzifier.sv
// Centre-of-gravity defuzzifier: accumulates mu*centre and mu over a frame,
// then divides sequentially (restoring, one quotient bit per clock).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_ACC  | accepting terms; num/den accumulate until the in_last term
// ST_LOAD | latch sign and |num| into the divider, arm the bit counter
// ST_DIV  | one restoring-division quotient bit per clock, ACC_W clocks
// ST_FIX  | apply sign, force 0 on zero weight, register the result
// ST_OUT  | result presented; wait for out_ready, then clear the frame
module fuzzy_defuzzifier #(
  parameter int CENTER_STEP = 256,
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_set_id,
  input  logic [7:0]       in_mu,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_crisp,
  output logic             out_bad_id,
  output logic             out_zero_w
);

  localparam int DEN_W = 16;

  typedef enum logic [2:0] {
    ST_ACC  = 3'd0,
    ST_LOAD = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             bad_id;
  logic             neg;
  logic [DEN_W-1:0] rem;
  logic [ACC_W-1:0] quo;
  logic [4:0]       cnt;

  logic             accept;
  logic             id_ok;
  logic [ACC_W-1:0] id_ext;
  logic [ACC_W-1:0] centre;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] num_mag;
  logic [DEN_W:0]   shifted;
  logic [DEN_W+1:0] diff;
  logic [ACC_W-1:0] fix_val;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid && in_ready;
  assign id_ok     = (in_set_id != 8'd0) && (in_set_id <= 8'd11);

  // Centre and product are formed modulo 2^ACC_W; two's complement bits
  // are identical to the signed result, so no signed casts are needed.
  always_comb begin
    id_ext  = ACC_W'(in_set_id);
    centre  = (id_ext - ACC_W'(6)) * ACC_W'(CENTER_STEP);
    term    = centre * ACC_W'(in_mu);
    num_mag = num[ACC_W-1] ? (~num + ACC_W'(1)) : num;
    shifted = {rem, quo[ACC_W-1]};
    diff    = {1'b0, shifted} - {2'b00, den};
    fix_val = neg ? (~quo + ACC_W'(1)) : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (accept && in_last) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_DIV;
      ST_DIV:  if (cnt == 5'd0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num        <= '0;
      den        <= '0;
      bad_id     <= 1'b0;
      neg        <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      out_crisp  <= '0;
      out_bad_id <= 1'b0;
      out_zero_w <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (id_ok) begin
              num <= num + term;
              den <= den + DEN_W'(in_mu);
            end else begin
              bad_id <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          neg <= num[ACC_W-1];
          quo <= num_mag;
          rem <= '0;
          cnt <= 5'(ACC_W - 1);
        end
        ST_DIV: begin
          // rem < den always holds, so a successful trial fits DEN_W bits
          if (!diff[DEN_W+1]) begin
            rem <= diff[DEN_W-1:0];
            quo <= {quo[ACC_W-2:0], 1'b1};
          end else begin
            rem <= shifted[DEN_W-1:0];
            quo <= {quo[ACC_W-2:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        ST_FIX: begin
          // magnitude division already truncates toward zero
          out_crisp  <= (den == '0) ? '0 : OUT_W'(fix_val);
          out_bad_id <= bad_id;
          out_zero_w <= (den == '0);
        end
        ST_OUT: begin
          if (out_ready) begin
            num        <= '0;
            den        <= '0;
            bad_id     <= 1'b0;
            out_bad_id <= 1'b0;
            out_zero_w <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
